// File: rtl/mux_scan_n.sv
`default_nettype none
// ============================================================================
// Module   : mux_scan_n
// Purpose  : Registered CH:1 channel selector with a loadable, range-checked
//            selection register and an auto-scan mode that steps through the
//            channels, dwelling DWELL cycles on each. The output word is
//            tagged with the index of the channel it was taken from.
// Ports    : clk        - rising-edge clock
//            rst_n      - asynchronous active-low reset
//            in         - CH packed channels, channel k = in[k*W +: W]
//            sel        - channel index to load
//            sel_load   - capture sel into the selection register
//            mode       - 0 = manual hold, 1 = auto-scan
//            hold       - freeze all state and outputs
//            out        - registered data of the selected channel
//            cur_sel    - index of the channel that produced out
//            out_valid  - out/cur_sel are meaningful
//            sel_err    - one-cycle pulse after a rejected out-of-range load
// Revision : 1.0 - initial release
// ============================================================================
module mux_scan_n #(
  parameter int CH    = 4,
  parameter int W     = 1,
  parameter int SELW  = 2,
  parameter int DWELL = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [CH*W-1:0] in,
  input  logic [SELW-1:0] sel,
  input  logic            sel_load,
  input  logic            mode,
  input  logic            hold,
  output logic [W-1:0]    out,
  output logic [SELW-1:0] cur_sel,
  output logic            out_valid,
  output logic            sel_err
);

  // Dwell counter needs at least one bit even when DWELL == 1.
  localparam int                CW           = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0]     c_dwell_last = CW'(DWELL - 1);
  localparam logic [SELW:0]     c_ch_count   = (SELW + 1)'(CH);
  localparam logic [SELW-1:0]   c_last_ch    = SELW'(CH - 1);

  logic [SELW-1:0] r_sel;
  logic [CW-1:0]   r_dwell;
  logic [W-1:0]    r_out;
  logic [SELW-1:0] r_cur;
  logic            r_valid;
  logic            r_err;

  logic [SELW-1:0] w_sel_nxt;
  logic [CW-1:0]   w_dwell_nxt;
  logic            w_err_nxt;
  logic            w_sel_ok;
  logic [W-1:0]    w_ch [CH];

  // Unpack the channels so the output mux indexes whole words: unselected
  // channels (including any X/Z on them) never feed the selected result.
  for (genvar k = 0; k < CH; k++) begin : g_unpack
    assign w_ch[k] = in[k*W +: W];
  end

  assign w_sel_ok = ({1'b0, sel} < c_ch_count);

  // Selection / dwell next state. A valid load beats a scan step. A rejected
  // load freezes the selection and counter for that cycle; in manual mode the
  // counter is still forced to zero so it is always 0 outside scan mode.
  always_comb begin
    w_sel_nxt   = r_sel;
    w_dwell_nxt = r_dwell;
    w_err_nxt   = 1'b0;
    if (sel_load && w_sel_ok) begin
      w_sel_nxt   = sel;
      w_dwell_nxt = '0;
    end else if (sel_load) begin
      w_err_nxt = 1'b1;
      if (!mode) begin
        w_dwell_nxt = '0;
      end
    end else if (!mode) begin
      w_dwell_nxt = '0;
    end else if (r_dwell == c_dwell_last) begin
      w_sel_nxt   = (r_sel == c_last_ch) ? '0 : r_sel + 1'b1;
      w_dwell_nxt = '0;
    end else begin
      w_dwell_nxt = r_dwell + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel   <= '0;
      r_dwell <= '0;
      r_out   <= '0;
      r_cur   <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else if (hold) begin
      // Everything frozen; only the error pulse is allowed to retire.
      r_err <= 1'b0;
    end else begin
      r_sel   <= w_sel_nxt;
      r_dwell <= w_dwell_nxt;
      r_out   <= w_ch[r_sel];
      r_cur   <= r_sel;
      r_valid <= 1'b1;
      r_err   <= w_err_nxt;
    end
  end

  assign out       = r_out;
  assign cur_sel   = r_cur;
  assign out_valid = r_valid;
  assign sel_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mux_scan_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_scan_n
// Purpose  : Self-checking bench for mux_scan_n (CH=6, W=8, SELW=3, DWELL=3).
//            A behavioural model tracks the selector and is compared against
//            the DUT on every falling edge; directed steps add literal checks.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mux_scan_n;

  localparam int CH    = 6;
  localparam int W     = 8;
  localparam int SELW  = 3;
  localparam int DWELL = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [CH*W-1:0] in;
  logic [SELW-1:0] sel;
  logic            sel_load;
  logic            mode;
  logic            hold;
  logic [W-1:0]    out;
  logic [SELW-1:0] cur_sel;
  logic            out_valid;
  logic            sel_err;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mux_scan_n #(.CH(CH), .W(W), .SELW(SELW), .DWELL(DWELL)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in       (in),
    .sel      (sel),
    .sel_load (sel_load),
    .mode     (mode),
    .hold     (hold),
    .out      (out),
    .cur_sel  (cur_sel),
    .out_valid(out_valid),
    .sel_err  (sel_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int              m_sel;
  int              m_cnt;
  logic [W-1:0]    m_out;
  logic [SELW-1:0] m_cur;
  logic            m_valid;
  logic            m_err;

  function automatic logic [W-1:0] chan(input int k);
    return in[k*W +: W];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sel <= 0; m_cnt <= 0; m_out <= '0; m_cur <= '0; m_valid <= 1'b0; m_err <= 1'b0;
    end else if (hold) begin
      m_err <= 1'b0;
    end else begin
      m_out   <= chan(m_sel);
      m_cur   <= SELW'(m_sel);
      m_valid <= 1'b1;
      m_err   <= sel_load && (int'(sel) >= CH);
      if (sel_load && int'(sel) < CH) begin
        m_sel <= int'(sel);
        m_cnt <= 0;
      end else if (sel_load) begin
        if (!mode) m_cnt <= 0;
      end else if (!mode) begin
        m_cnt <= 0;
      end else if (m_cnt == DWELL - 1) begin
        m_sel <= (m_sel + 1) % CH;
        m_cnt <= 0;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  always @(negedge clk) begin
    check("model_out",     64'(out),       64'(m_out));
    check("model_cur_sel", 64'(cur_sel),   64'(m_cur));
    check("model_valid",   64'(out_valid), 64'(m_valid));
    check("model_sel_err", 64'(sel_err),   64'(m_err));
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_ramp();
    for (int k = 0; k < CH; k++) in[k*W +: W] = 8'h10 + 8'(k);
  endtask

  int exp_cur [19] = '{0,0,0,1,1,1,2,2,2,3,3,3,4,4,4,5,5,5,0};

  initial begin
    rst_n = 1'b0; sel = '0; sel_load = 1'b0; mode = 1'b1; hold = 1'b0;
    set_ramp();
    #1;
    check("reset_out",   64'(out),       64'h0);
    check("reset_valid", 64'(out_valid), 64'h0);
    check("reset_cur",   64'(cur_sel),   64'h0);
    check("reset_err",   64'(sel_err),   64'h0);
    step(); step();
    rst_n = 1'b1;

    // Scan wrap with dwell 3
    for (int k = 0; k < 19; k++) begin
      step();
      check("scan_cur", 64'(cur_sel), 64'(exp_cur[k]));
      check("scan_out", 64'(out),     64'(8'h10 + exp_cur[k]));
      if (k == 0) check("first_valid", 64'(out_valid), 64'h1);
    end

    // Out-of-range load
    sel = 3'd7; sel_load = 1'b1;
    step();
    sel_load = 1'b0;
    check("err_pulse", 64'(sel_err), 64'h1);
    step();
    check("err_drop", 64'(sel_err), 64'h0);

    // Load coinciding with a scan step
    for (int i = 0; i < 10 && m_cnt != DWELL - 1; i++) step();
    check("align_step", 64'(m_cnt), 64'(DWELL - 1));
    sel = 3'd4; sel_load = 1'b1;
    step();
    sel_load = 1'b0;
    step(); check("prio_cur_a", 64'(cur_sel), 64'd4);
    step(); check("prio_cur_b", 64'(cur_sel), 64'd4);
    step(); check("prio_cur_c", 64'(cur_sel), 64'd4);
    step(); check("prio_cur_d", 64'(cur_sel), 64'd5);

    // Hold mid-scan with an ignored load
    hold = 1'b1; sel = 3'd1; sel_load = 1'b1;
    repeat (5) step();
    check("hold_no_err", 64'(sel_err), 64'h0);
    hold = 1'b0; sel_load = 1'b0;
    repeat (4) step();

    // Manual load and latency
    mode = 1'b0; sel = 3'd1; sel_load = 1'b1;
    step();
    sel_load = 1'b0;
    in[1*W +: W] = 8'hA5;
    step();
    check("man_cur", 64'(cur_sel), 64'd1);
    check("man_out", 64'(out),     64'hA5);
    in[1*W +: W] = 8'h5A;
    step();
    check("man_out2", 64'(out), 64'h5A);

    // Isolation: only channel 0 may reach out
    sel = 3'd0; sel_load = 1'b1;
    step();
    sel_load = 1'b0;
    in[0 +: W] = 8'h3C;
    for (int i = 0; i < 8; i++) begin
      for (int k = 1; k < CH; k++) in[k*W +: W] = 8'($urandom());
      step();
      check("iso_out", 64'(out), 64'h3C);
    end

    // Random mixed traffic, model-checked
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < CH; k++) in[k*W +: W] = 8'($urandom());
      sel      = 3'($urandom_range(0, 7));
      sel_load = ($urandom_range(0, 3) == 0);
      hold     = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      step();
    end

    // Asynchronous reset between edges
    hold = 1'b0; sel_load = 1'b0; mode = 1'b1;
    set_ramp();
    step();
    rst_n = 1'b0;
    #1;
    check("areset_out",   64'(out),       64'h0);
    check("areset_valid", 64'(out_valid), 64'h0);
    check("areset_cur",   64'(cur_sel),   64'h0);
    step(); step();
    rst_n = 1'b1;
    step();
    check("restart_cur", 64'(cur_sel), 64'd0);
    check("restart_out", 64'(out),     64'h10);
    repeat (3) step();
    check("restart_adv", 64'(cur_sel), 64'd1);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mux_scan_n.md
Name: mux_scan_n

Overview:
- Parametrised, registered N:1 channel selector. Generalises the team's 4:1 bit mux to CH channels of W bits each.
- Adds a selection register with load and range checking, and an auto-scan mode that steps through the channels at a programmable dwell.
- Output is registered and tagged with the channel it came from. Sits between multi-source sensor/data buses and single-lane consumers.

Parameters:
CH, 4, number of input channels (2..2^SELW)
W, 1, bits per channel
SELW, 2, width of select/index fields; CH <= 2^SELW
DWELL, 1, cycles spent on each channel in scan mode (>=1)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous, active-low reset
in  in  CH*W  packed channels; channel k = in[k*W +: W]
sel  in  SELW  channel index to load
sel_load  in  1  capture sel into selection register this cycle
mode  in  1  0 = manual (hold loaded selection), 1 = auto-scan
hold  in  1  freeze all state and outputs
out  out  W  registered data of selected channel
cur_sel  out  SELW  channel index that produced current out
out_valid  out  1  out/cur_sel are meaningful
sel_err  out  1  one-cycle pulse: rejected out-of-range load

Behaviour:
- Reset (rst_n=0, immediate, no clock needed): sel_q=0, dwell_cnt=0, out=0, cur_sel=0, out_valid=0, sel_err=0.
- Datapath: on each non-hold edge, out <= in[sel_q] and cur_sel <= sel_q. sel_q is the value held before the edge. Latency is 1 cycle from sel_q/in to out.
- out_valid: goes 1 on the first non-hold edge after reset release and stays 1 until the next reset. hold does not clear it.
- Load: sel_load=1 with sel<CH sets sel_q <= sel and clears dwell_cnt. The new channel appears on out one edge later, i.e. 2 edges after sel_load is sampled.
- Range check: sel_load=1 with sel>=CH leaves sel_q and dwell_cnt unchanged, and sel_err=1 for exactly the next cycle.
- Manual mode (mode=0): sel_q changes only by a valid load. dwell_cnt is held at 0.
- Scan mode (mode=1): dwell_cnt counts 0..DWELL-1. On an edge where dwell_cnt==DWELL-1, sel_q <= (sel_q==CH-1) ? 0 : sel_q+1 and dwell_cnt <= 0. With DWELL=1, sel_q advances every cycle.
- Simultaneous load and scan step: the load wins. sel_q <= sel, dwell_cnt <= 0, and no increment that cycle.
- Mode switch 1->0: sel_q keeps its current value and dwell_cnt clears. Switch 0->1: scanning starts from the current sel_q with dwell_cnt=0.
- hold=1: sel_q, dwell_cnt, out and cur_sel are all frozen. sel_load is ignored, and no sel_err is raised for it. sel_err drops to 0 on the next edge. Releasing hold resumes exactly from the frozen state.
- X semantics: out depends only on the selected channel. X/Z on unselected channels must not reach out. X on the selected channel passes through as X.
- Reset mid-scan: state returns immediately to reset values. Scanning restarts at channel 0 after release.
- No combinational path from any input to any output.

Test Plan:
- Reset/valid: CH=4, W=1, in=4'b1010, rst_n low then high, mode=0 -> out=0, out_valid=0 during reset; after first edge out=0 (ch0) and out_valid=1.
- Manual load and latency: sel=2'b01 with sel_load pulsed, in=4'b0010 -> sel_q=1 after edge 1; edge 2 gives out=1, cur_sel=1. in=4'b0100 -> out=0 next edge.
- X isolation: in=4'bXXX0 with sel_q=0 -> out=0, not X. in=4'b1X10 with sel_q=3 -> out=1. Then sel_q=2 with in=4'b1X10 -> out=X is allowed.
- Scan wrap with dwell: CH=6, W=8, DWELL=3, mode=1, in channel k = 8'h10+k -> cur_sel sequence 0,0,0,1,1,1,…,5,5,5,0; out matches 8'h10..8'h15 in step.
- Out-of-range and priority: CH=6, SELW=3, sel=3'd7 with sel_load -> sel_err high for 1 cycle, sel_q unchanged. Then sel=3'd4 with sel_load on a scan-step edge -> sel_q=4 and dwell restarts.
- Hold and async reset: hold=1 for 5 cycles mid-scan -> out and cur_sel constant, sel_load ignored; after release scan continues from the frozen channel. Assert rst_n low between edges -> outputs clear immediately.
